// File: rtl/demux1to4_buf_pkg.sv
// Shared types and constants for the 1-to-4 demultiplexer and its mux counterpart.
package demux_pkg;

    localparam int DEMUX_DATA_W = 32;

    // Selector encoding shared with the 4-to-1 selector mux
    localparam logic [1:0] SEL_OUT1 = 2'b00;
    localparam logic [1:0] SEL_OUT2 = 2'b01;
    localparam logic [1:0] SEL_OUT3 = 2'b10;
    localparam logic [1:0] SEL_OUT4 = 2'b11;

    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_t;

endpackage

// File: rtl/demux1to4_buf_if.sv
// Producer and consumer-lane signals of demux1to4_buf; slave is the block side.
interface demux1to4_buf_if
    import demux_pkg::*;
#(
    parameter int DATA_W = DEMUX_DATA_W
);
    logic [DATA_W-1:0] in_data;
    logic [1:0]        in_sel;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out1;
    logic [DATA_W-1:0] out2;
    logic [DATA_W-1:0] out3;
    logic [DATA_W-1:0] out4;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out1, out2, out3, out4, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out1, out2, out3, out4, out_valid
    );
endinterface

// File: rtl/demux1to4_buf_slot.sv
// One-entry lane buffer: EMPTY/FULL state, data register and optional accept counter.
// The counter exists only when DEMUX_CNT_EN is defined.
module demux_slot
    import demux_pkg::*;
#(
    parameter int DATA_W = DEMUX_DATA_W
`ifdef DEMUX_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    input  logic              drain,
    output logic [DATA_W-1:0] dout,
    output logic              valid
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0]  cnt
`endif
);
    lane_state_t       state_r;
    lane_state_t       state_s;
    logic [DATA_W-1:0] data_r;

    // Lane state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= LANE_EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state: a load wins over a same-edge drain, keeping the lane full
    always_comb begin
        state_s = state_r;
        case (state_r)
            LANE_EMPTY: begin
                if (load) begin
                    state_s = LANE_FULL;
                end else begin
                    state_s = LANE_EMPTY;
                end
            end
            LANE_FULL: begin
                if (load) begin
                    state_s = LANE_FULL;
                end else if (drain) begin
                    state_s = LANE_EMPTY;
                end else begin
                    state_s = LANE_FULL;
                end
            end
            default: state_s = LANE_EMPTY;
        endcase
    end

    // Data register keeps its last word after a drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r <= {DATA_W{1'b0}};
        end else if (load) begin
            data_r <= din;
        end
    end

    assign dout  = data_r;
    assign valid = (state_r == LANE_FULL);

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt_r;

    // Accept counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign cnt = cnt_r;
`endif

endmodule

// File: rtl/demux1to4_buf.sv
// Registered 1-to-4 demultiplexer with one-entry buffer per lane.
// Optional per-lane accept counters are enabled by the DEMUX_CNT_EN macro.
module demux1to4_buf
    import demux_pkg::*;
#(
    parameter int DATA_W = DEMUX_DATA_W
`ifdef DEMUX_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    demux1to4_buf_if.slave   bus
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0] out_cnt1,
    output logic [CNT_W-1:0] out_cnt2,
    output logic [CNT_W-1:0] out_cnt3,
    output logic [CNT_W-1:0] out_cnt4
`endif
);
    logic [3:0]        load_s;
    logic [3:0]        valid_s;
    logic              ready_s;
    logic              accept_s;
    logic [DATA_W-1:0] data_s [4];
`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0]  cnt_s [4];
`endif

    // out_ready feeds in_ready combinationally so a draining lane can refill at once
    assign ready_s  = !rst && (!valid_s[bus.in_sel] || bus.out_ready[bus.in_sel]);
    assign accept_s = bus.in_valid && ready_s;

    // Selector decode into a one-hot lane load
    always_comb begin
        load_s = 4'b0000;
        if (accept_s) begin
            case (bus.in_sel)
                SEL_OUT1: load_s = 4'b0001;
                SEL_OUT2: load_s = 4'b0010;
                SEL_OUT3: load_s = 4'b0100;
                SEL_OUT4: load_s = 4'b1000;
                default:  load_s = 4'b0000;
            endcase
        end else begin
            load_s = 4'b0000;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_slot
        demux_slot #(
            .DATA_W (DATA_W)
`ifdef DEMUX_CNT_EN
            ,
            .CNT_W  (CNT_W)
`endif
        ) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (load_s[i]),
            .din   (bus.in_data),
            .drain (bus.out_ready[i]),
            .dout  (data_s[i]),
            .valid (valid_s[i])
`ifdef DEMUX_CNT_EN
            ,
            .cnt   (cnt_s[i])
`endif
        );
    end

    assign bus.in_ready  = ready_s;
    assign bus.out_valid = valid_s;
    assign bus.out1      = data_s[0];
    assign bus.out2      = data_s[1];
    assign bus.out3      = data_s[2];
    assign bus.out4      = data_s[3];

`ifdef DEMUX_CNT_EN
    assign out_cnt1 = cnt_s[0];
    assign out_cnt2 = cnt_s[1];
    assign out_cnt3 = cnt_s[2];
    assign out_cnt4 = cnt_s[3];
`endif

endmodule

// File: tb/tb_demux1to4_buf.sv
// Directed self-checking bench for demux1to4_buf; counter checks run when DEMUX_CNT_EN is defined.
module tb_demux1to4_buf;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    demux1to4_buf_if #(.DATA_W(32)) bus ();

`ifdef DEMUX_CNT_EN
    logic [3:0] out_cnt1;
    logic [3:0] out_cnt2;
    logic [3:0] out_cnt3;
    logic [3:0] out_cnt4;

    demux1to4_buf #(.DATA_W(32), .CNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .out_cnt1 (out_cnt1),
        .out_cnt2 (out_cnt2),
        .out_cnt3 (out_cnt3),
        .out_cnt4 (out_cnt4)
    );
`else
    demux1to4_buf #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are then changed 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [31:0] d);
        bus.in_valid = v;
        bus.in_sel   = sel;
        bus.in_data  = d;
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'b00;
        bus.in_data   = 32'h0;
        bus.out_ready = 4'b0000;
        #1 rst = 1'b1;
        #1;
        check_eq("rst_valid", 64'(bus.out_valid), 64'h0);
        check_eq("rst_ready", 64'(bus.in_ready), 64'h0);
        tick();
        rst = 1'b0;
        #1;
        check_eq("rel_ready", 64'(bus.in_ready), 64'h1);

        // Basic routing, one word per cycle to each lane
        bus.out_ready = 4'b1111;
        drive(1'b1, 2'b00, 32'hA0000001);
        check_eq("route1_rdy", 64'(bus.in_ready), 64'h1);
        tick();
        drive(1'b1, 2'b01, 32'hB0000002);
        check_eq("route1_out", 64'(bus.out1), 64'hA0000001);
        check_eq("route1_vld", 64'(bus.out_valid), 64'h1);
        check_eq("route2_rdy", 64'(bus.in_ready), 64'h1);
        tick();
        drive(1'b1, 2'b10, 32'hC0000003);
        check_eq("route2_out", 64'(bus.out2), 64'hB0000002);
        check_eq("route2_vld", 64'(bus.out_valid), 64'h2);
        check_eq("route3_rdy", 64'(bus.in_ready), 64'h1);
        tick();
        drive(1'b1, 2'b11, 32'hD0000004);
        check_eq("route3_out", 64'(bus.out3), 64'hC0000003);
        check_eq("route3_vld", 64'(bus.out_valid), 64'h4);
        check_eq("route4_rdy", 64'(bus.in_ready), 64'h1);
        tick();
        drive(1'b0, 2'b00, 32'h0);
        check_eq("route4_out", 64'(bus.out4), 64'hD0000004);
        check_eq("route4_vld", 64'(bus.out_valid), 64'h8);
        tick();
        check_eq("route_empty", 64'(bus.out_valid), 64'h0);
        check_eq("route_keep", 64'(bus.out4), 64'hD0000004);

        // Backpressure on lane 1
        bus.out_ready = 4'b1110;
        drive(1'b1, 2'b00, 32'h11);
        tick();
        drive(1'b1, 2'b00, 32'h22);
        check_eq("bp_out", 64'(bus.out1), 64'h11);
        check_eq("bp_blocked", 64'(bus.in_ready), 64'h0);
        tick();
        check_eq("bp_hold_out", 64'(bus.out1), 64'h11);
        check_eq("bp_hold_vld", 64'(bus.out_valid), 64'h1);

        // Independence: lane 2 accepts while lane 1 stays stalled
        drive(1'b1, 2'b01, 32'h33);
        check_eq("ind_rdy", 64'(bus.in_ready), 64'h1);
        tick();
        drive(1'b0, 2'b00, 32'h0);
        check_eq("ind_out", 64'(bus.out2), 64'h33);
        check_eq("ind_vld", 64'(bus.out_valid), 64'h3);
        tick();
        check_eq("ind_drain", 64'(bus.out_valid), 64'h1);

        // Release lane 1: 0x22 accepted in the same cycle
        bus.out_ready = 4'b1111;
        drive(1'b1, 2'b00, 32'h22);
        check_eq("bp_release_rdy", 64'(bus.in_ready), 64'h1);
        tick();
        drive(1'b0, 2'b00, 32'h0);
        check_eq("bp_release_out", 64'(bus.out1), 64'h22);
        check_eq("bp_release_vld", 64'(bus.out_valid), 64'h1);
        tick();

        // Same-cycle drain and fill on lane 4
        bus.out_ready = 4'b0111;
        drive(1'b1, 2'b11, 32'h44);
        tick();
        drive(1'b0, 2'b00, 32'h0);
        check_eq("df_first", 64'(bus.out4), 64'h44);
        bus.out_ready = 4'b1111;
        drive(1'b1, 2'b11, 32'h55);
        check_eq("df_rdy", 64'(bus.in_ready), 64'h1);
        tick();
        drive(1'b0, 2'b00, 32'h0);
        check_eq("df_vld", 64'(bus.out_valid), 64'h8);
        check_eq("df_out", 64'(bus.out4), 64'h55);
        tick();
        check_eq("df_empty", 64'(bus.out_valid), 64'h0);

        // Reset mid-stream with lanes 2 and 3 full
        bus.out_ready = 4'b0000;
        drive(1'b1, 2'b01, 32'h66);
        tick();
        drive(1'b1, 2'b10, 32'h77);
        tick();
        drive(1'b1, 2'b01, 32'h88);
        check_eq("pre_rst_vld", 64'(bus.out_valid), 64'h6);
        check_eq("pre_rst_rdy", 64'(bus.in_ready), 64'h0);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_vld", 64'(bus.out_valid), 64'h0);
        check_eq("mid_rst_out", {bus.out2, bus.out3}, 64'h0);
        check_eq("mid_rst_out14", {bus.out1, bus.out4}, 64'h0);
        check_eq("mid_rst_rdy", 64'(bus.in_ready), 64'h0);
        tick();
        drive(1'b0, 2'b01, 32'h0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_rdy", 64'(bus.in_ready), 64'h1);
        tick();
        check_eq("post_rst_vld", 64'(bus.out_valid), 64'h0);

`ifdef DEMUX_CNT_EN
        // 17 accepts into lane 3 wrap a 4-bit counter to 1
        bus.out_ready = 4'b1111;
        drive(1'b1, 2'b10, 32'h99);
        for (int i = 0; i < 17; i++) begin
            tick();
        end
        drive(1'b0, 2'b00, 32'h0);
        check_eq("cnt3_wrap", 64'(out_cnt3), 64'h1);
        check_eq("cnt_others", {out_cnt1, out_cnt2, out_cnt4}, 64'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/demux1to4_buf.md
Name: demux1to4_buf

Overview:
- Registered 1-to-4 demultiplexer: the distributing counterpart of the 4-to-1 selector mux.
- Accepts one 32-bit word per cycle over a valid/ready handshake and steers it by a 2-bit selector into one of four one-entry output buffers.
- Each output buffer is drained independently by its own valid/ready handshake.
- Sits between a single producer and four consumer lanes. Selector encoding matches the mux: 00→out1, 01→out2, 10→out3, 11→out4.

Parameters:
DATA_W, 32, width of data words
CNT_W, 16, width of per-output transfer counters (used only with DEMUX_CNT_EN)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_data  input  DATA_W  word to distribute
in_sel  input  2  destination select, sampled only on accept
in_valid  input  1  producer has a word
in_ready  output  1  block can accept this cycle
out1..out4  output  DATA_W each  buffered data for lanes 1-4
out_valid  output  4  bit i = lane i+1 buffer full
out_ready  input  4  bit i = lane i+1 consumer takes word
out_cnt1..out_cnt4  output  CNT_W each  accepted-word counters (only with DEMUX_CNT_EN)

Interface rule: one clock; reset is asynchronous and active-high.

Behaviour:
- Per lane i, a 2-state FSM:
  - EMPTY: out_valid[i]=0.
  - FULL: out_valid[i]=1, out_i holds the word.
- Reset (async assert, any cycle):
  - all lanes go EMPTY; out_valid=0; out1..out4=0; counters=0.
  - in_ready=0 while rst=1.
  - Words held at reset are discarded, with no partial output.
- in_ready = !rst && (!out_valid[s] || out_ready[s]), where s=in_sel.
  - This is a combinational path from out_ready to in_ready; a full lane that drains in the same cycle accepts a new word.
- Accept = in_valid && in_ready at the clock edge. On accept:
  - in_data is loaded into lane s; lane s is FULL next cycle.
  - Latency is 1 cycle, in_data to out_s with out_valid[s]=1.
- Drain = out_valid[i] && out_ready[i]:
  - Lane i goes EMPTY next cycle, unless the same edge also accepts into lane i.
  - Simultaneous drain and accept on one lane: the lane stays FULL with the new word.
- Lanes are independent:
  - A drain on one lane never blocks accepts to another lane.
  - A stalled lane blocks only inputs that target it (head-of-line blocking at the input is intended).
- While FULL and not drained, out_i and out_valid[i] hold stable.
- After a drain, out_i keeps its last value; consumers must qualify it with out_valid.
- in_valid without accept: nothing changes. Producer may change in_data/in_sel freely before accept (valid/ready, not sticky).
- Throughput: 1 word/cycle sustained to any lane whose consumer holds out_ready=1.

Optional Feature:
- Macro DEMUX_CNT_EN.
- Defined:
  - Ports out_cnt1..out_cnt4 exist.
  - Each counter increments by 1 on every accept into its lane.
  - Counters wrap from 2^CNT_W-1 to 0; cleared only by rst.
- Undefined: counter ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package demux_pkg:
  - DATA_W default.
  - Selector constants SEL_OUT1=2'b00, SEL_OUT2=2'b01, SEL_OUT3=2'b10, SEL_OUT4=2'b11, shared with the mux side.
  - Lane-state enum {LANE_EMPTY, LANE_FULL}.
- Sub-module demux_slot: one-entry buffer holding data reg, valid flag and optional counter, with load/drain inputs. Instantiated 4 times.
- Top-level logic: selector decode and in_ready generation.

Test Plan:
- Reset check: rst=1 mid-stream with lanes 2 and 3 FULL → out_valid=0000, out1..4=0, in_ready=0; after release in_ready=1.
- Basic routing: out_ready=1111; send 0xA0000001 (sel 00), 0xB0000002 (01), 0xC0000003 (10), 0xD0000004 (11) back to back → each word appears one cycle later on out1..out4 respectively with the matching out_valid bit, 4 accepts in 4 cycles.
- Backpressure: out_ready[0]=0; send 0x11 then 0x22 to sel 00 → 0x11 held on out1, in_ready=0 for the second word. Raise out_ready[0] → 0x22 accepted the same cycle and appears next cycle.
- Independence: lane 1 stalled FULL; send 0x33 to sel 01 → accepted immediately, out2=0x33, out_valid=0011.
- Same-cycle drain+fill: lane 4 FULL with 0x44, out_ready[3]=1, input 0x55 sel 11 → out_valid[3] stays 1, out4=0x55 next cycle.
- DEMUX_CNT_EN, CNT_W=4: 17 accepts to lane 3 → out_cnt3=1 (wrapped), other counters 0.
